// File: rtl/alu_dispatch_pkg.sv
// Shared ALU dispatch definitions: data/select widths, opcode codes and dispatcher state encoding.
package alu_dispatch_pkg;

   localparam int WIDTH        = 8;
   localparam int SELECT_WIDTH = 3;

   typedef logic [SELECT_WIDTH-1:0] op_t;

   localparam op_t OP_ADD   = 3'd0;
   localparam op_t OP_SUB   = 3'd1;
   localparam op_t OP_OR    = 3'd2;
   localparam op_t OP_AND   = 3'd3;
   localparam op_t OP_ADC   = 3'd4;
   localparam op_t OP_SBB   = 3'd5;
   localparam op_t OP_NOT   = 3'd6;
   localparam op_t OP_PRINT = 3'd7;

   typedef enum logic [1:0] {
      DSP_IDLE = 2'd0,
      DSP_EXEC = 2'd1,
      DSP_RESP = 2'd2
   } dsp_state_e;

endpackage

// File: rtl/alu_dispatch.sv
// ALU command front end: one op in flight, holds select/operands while the output selector settles,
// then captures d/cout, updates the carry flag and offers the result until the consumer takes it.
module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [SELECT_WIDTH-1:0] cmd_op,
   input  logic [WIDTH-1:0]        cmd_a,
   input  logic [WIDTH-1:0]        cmd_b,
   input  logic                    cf_clr,
   output logic [WIDTH-1:0]        alu_a,
   output logic [WIDTH-1:0]        alu_b,
   output logic                    alu_cin,
   output logic [SELECT_WIDTH-1:0] alu_s,
   input  logic [WIDTH-1:0]        alu_d,
   input  logic                    alu_cout,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [WIDTH-1:0]        res_d,
   output logic                    res_cout,
   output logic                    cf
);

   localparam logic [2:0] LAT_CNT = 3'(LAT);

   function automatic logic updates_carry(input op_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
   endfunction

   dsp_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic              alu_cin_q, alu_cin_d;
   op_t               alu_s_q, alu_s_d;
   logic              res_valid_q, res_valid_d;
   logic [WIDTH-1:0]  res_d_q, res_d_d;
   logic              res_cout_q, res_cout_d;
   logic              cf_q, cf_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_cin_d   = alu_cin_q;
      alu_s_d     = alu_s_q;
      res_valid_d = res_valid_q;
      res_d_d     = res_d_q;
      res_cout_d  = res_cout_q;
      cf_d        = cf_clr ? 1'b0 : cf_q;

      case (state_q)
         DSP_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               alu_s_d     = cmd_op;
               alu_a_d     = cmd_a;
               alu_b_d     = cmd_b;
               alu_cin_d   = cf_q;
               cnt_d       = LAT_CNT;
               cmd_ready_d = 1'b0;
               state_d     = DSP_EXEC;
            end
         end
         DSP_EXEC: begin
            // Counter runs LAT down to 0; capturing on the edge after it hits 0 gives the
            // selector its full LAT register stages behind the accept edge.
            if (cnt_q == 3'd0) begin
               res_d_d     = alu_d;
               res_cout_d  = alu_cout;
               res_valid_d = 1'b1;
               state_d     = DSP_RESP;
               if (!cf_clr && updates_carry(alu_s_q)) begin
                  cf_d = alu_cout;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DSP_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = DSP_IDLE;
            end
         end
         default: begin
            state_d     = DSP_IDLE;
            cmd_ready_d = 1'b1;
            res_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= DSP_IDLE;
         cnt_q       <= 3'd0;
         cmd_ready_q <= 1'b1;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_cin_q   <= 1'b0;
         alu_s_q     <= OP_ADD;
         res_valid_q <= 1'b0;
         res_d_q     <= '0;
         res_cout_q  <= 1'b0;
         cf_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_cin_q   <= alu_cin_d;
         alu_s_q     <= alu_s_d;
         res_valid_q <= res_valid_d;
         res_d_q     <= res_d_d;
         res_cout_q  <= res_cout_d;
         cf_q        <= cf_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_cin   = alu_cin_q;
   assign alu_s     = alu_s_q;
   assign res_valid = res_valid_q;
   assign res_d     = res_d_q;
   assign res_cout  = res_cout_q;
   assign cf        = cf_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: models the functional units plus a LAT-stage registered selector,
// issues directed and random ops, and scores results through a queue drained by a monitor.
module tb_alu_dispatch;
   import alu_dispatch_pkg::*;

   localparam int LAT = 3;
   localparam int W   = WIDTH;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    cmd_valid, cmd_ready;
   logic [SELECT_WIDTH-1:0] cmd_op;
   logic [W-1:0]            cmd_a, cmd_b;
   logic                    cf_clr;
   logic [W-1:0]            alu_a, alu_b, alu_d;
   logic                    alu_cin, alu_cout;
   logic [SELECT_WIDTH-1:0] alu_s;
   logic                    res_valid, res_ready;
   logic [W-1:0]            res_d;
   logic                    res_cout, cf;

   always #5 clk = ~clk;

   alu_dispatch #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cf_clr(cf_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s(alu_s),
      .alu_d(alu_d), .alu_cout(alu_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_d(res_d), .res_cout(res_cout), .cf(cf)
   );

   typedef struct {
      logic [W-1:0] d;
      logic         cout;
      logic         cf;
      int           acc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   logic m_cf = 1'b0;
   int   hold_cnt = 0;
   bit   rand_ready = 1'b0;

   // Carry out of SUB/SBB is the borrow (bit W of the 9-bit difference).
   function automatic logic [W:0] unit_model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
      logic [W:0] xa, xb, xc;
      xa = {1'b0, a};
      xb = {1'b0, b};
      xc = {{W{1'b0}}, cin};
      case (op)
         OP_ADD:  return xa + xb;
         OP_SUB:  return xa - xb;
         OP_ADC:  return xa + xb + xc;
         OP_SBB:  return xa - xb - xc;
         OP_OR:   return {1'b0, a | b};
         OP_AND:  return {1'b0, a & b};
         OP_NOT:  return {1'b0, ~a};
         default: return {1'b0, a};
      endcase
   endfunction

   logic [W:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= unit_model(alu_s, alu_a, alu_b, alu_cin);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign alu_cout = pipe[LAT-1][W];
   assign alu_d    = pipe[LAT-1][W-1:0];

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_alu_a"},     alu_a, 0);
      chk({tag, "_alu_b"},     alu_b, 0);
      chk({tag, "_alu_s"},     alu_s, OP_ADD);
      chk({tag, "_alu_cin"},   alu_cin, 0);
      chk({tag, "_res_d"},     res_d, 0);
      chk({tag, "_res_cout"},  res_cout, 0);
      chk({tag, "_cf"},        cf, 0);
   endtask

   task automatic send(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit clr_cap);
      logic [W:0] r;
      logic       cin;
      int         budget;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      budget    = 0;
      while (!cmd_ready) begin
         @(negedge clk);
         budget++;
         if (budget > 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd_ready=%0b after 200 cycles, required 1", cmd_ready);
            return;
         end
      end
      cin  = m_cf;
      r    = unit_model(op, a, b, cin);
      m_cf = clr_cap ? 1'b0 :
             (op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBB}) ? r[W] : m_cf;
      @(negedge clk);
      sbq.push_back('{d: r[W-1:0], cout: r[W], cf: m_cf, acc: cycle});
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) @(negedge clk);
         if (k == LAT && clr_cap) cf_clr = 1'b1;
         chk("alu_s_exec",     alu_s, op);
         chk("alu_a_exec",     alu_a, a);
         chk("alu_b_exec",     alu_b, b);
         chk("alu_cin_exec",   alu_cin, cin);
         chk("cmd_ready_exec", cmd_ready, 0);
         chk("res_valid_exec", res_valid, 0);
      end
      if (clr_cap) begin
         @(negedge clk);
         cf_clr = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (!(cmd_ready && sbq.size() == 0)) begin
         @(negedge clk);
         budget++;
         if (budget > 300) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: cmd_ready=%0b pending=%0d, required 1/0", cmd_ready, sbq.size());
            return;
         end
      end
   endtask

   initial begin
      res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (hold_cnt > 0 && res_valid) begin
            res_ready = 1'b0;
            hold_cnt--;
         end else if (rand_ready) begin
            res_ready = ($urandom_range(0, 3) != 0);
         end else begin
            res_ready = 1'b1;
         end
      end
   end

   bit   mon_prev_v = 1'b0;
   bit   mon_hs = 1'b0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_prev_v = 1'b0;
            mon_hs     = 1'b0;
            continue;
         end
         if (mon_hs) begin
            chk("cmd_ready_after_hs", cmd_ready, 1);
            chk("res_valid_after_hs", res_valid, 0);
            mon_hs = 1'b0;
         end
         if (res_valid && !mon_prev_v) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: res_d=%0h with nothing outstanding", res_d);
            end else begin
               mon_e = sbq.pop_front();
               chk("latency",  cycle - mon_e.acc, LAT + 1);
               chk("res_d",    res_d, mon_e.d);
               chk("res_cout", res_cout, mon_e.cout);
               chk("cf",       cf, mon_e.cf);
            end
         end else if (res_valid) begin
            chk("res_d_hold",    res_d, mon_e.d);
            chk("res_cout_hold", res_cout, mon_e.cout);
         end
         if (res_valid) chk("cmd_ready_resp", cmd_ready, 0);
         if (res_valid && res_ready) mon_hs = 1'b1;
         mon_prev_v = res_valid;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_ADD;
      cmd_a     = '0;
      cmd_b     = '0;
      cf_clr    = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("in_reset");
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("after_reset");

      send(OP_ADD, 8'hF0, 8'h20, 1'b0);
      send(OP_ADD, 8'hFF, 8'h01, 1'b0);
      send(OP_ADC, 8'h00, 8'h00, 1'b0);
      send(OP_ADD, 8'hFF, 8'h01, 1'b0);
      send(OP_AND, 8'h0F, 8'h3C, 1'b0);
      send(OP_NOT, 8'hAA, 8'h00, 1'b0);
      hold_cnt = 5;
      send(OP_OR, 8'h12, 8'h34, 1'b0);
      send(OP_PRINT, 8'h5A, 8'h00, 1'b0);
      send(OP_SUB, 8'h00, 8'h01, 1'b1);

      send(OP_ADD, 8'hFF, 8'h01, 1'b0);
      cmd_valid = 1'b0;
      wait_idle();
      chk("cf_before_idle_clr", cf, 1);
      cf_clr = 1'b1;
      @(negedge clk);
      cf_clr = 1'b0;
      m_cf   = 1'b0;
      chk("cf_idle_clr", cf, 0);

      // Reset in the second EXEC cycle of an op that would set cf.
      send(OP_ADD, 8'hFF, 8'h01, 1'b0);
      cmd_valid = 1'b0;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_a     = 8'hC0;
      cmd_b     = 8'h80;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_vals("mid_exec_reset");
      @(negedge clk);
      rst  = 1'b0;
      m_cf = 1'b0;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         chk("no_result_after_rst", res_valid, 0);
      end
      send(OP_ADD, 8'h01, 8'h02, 1'b0);

      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         send(op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 1) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      cmd_valid  = 1'b0;
      rand_ready = 1'b0;
      wait_idle();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
